// File: rtl/load_down_timer_pkg.sv
// load_down_timer_pkg: shared state encoding and default width for the down timer.
package load_down_timer_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} tmr_state_e;
endpackage

// File: rtl/load_down_timer_core.sv
// down_cnt_core: preset and count registers with load/reload/decrement/hold and zero/one flags.
module down_cnt_core
  import load_down_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             reload_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] q_o,
  output logic             zero_o,
  output logic             one_o,
  output logic             preset_zero_o
);
  logic [WIDTH-1:0] q_q, q_d, preset_q, preset_d;
  assign zero_o        = q_q == '0;
  assign one_o         = q_q == WIDTH'(1);
  assign preset_zero_o = preset_q == '0;
  assign q_o           = q_q;
  // Decrement saturates at zero so the count never wraps.
  always_comb begin
    preset_d = load_i ? data_i : preset_q;
    q_d      = load_i ? data_i :
               reload_i ? preset_q :
               (dec_i && !zero_o) ? q_q - WIDTH'(1) : q_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      preset_q <= '0;
    end else begin
      q_q      <= q_d;
      preset_q <= preset_d;
    end
  end
endmodule

// File: rtl/load_down_timer.sv
// load_down_timer: loadable down-counting timer with pause, terminal-count pulse and done flag.
// Define LOAD_DOWN_TIMER_AUTORELOAD_EN to reload the preset on terminal count instead of stopping.
module load_down_timer
  import load_down_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  tmr_state_e state_q, state_d;
  logic tc_q, tc_d, reload, dec, zero, one, preset_zero;
  down_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .data_i       (data),
    .reload_i     (reload),
    .dec_i        (dec),
    .q_o          (q),
    .zero_o       (zero),
    .one_o        (one),
    .preset_zero_o(preset_zero)
  );
  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    reload  = 1'b0;
    dec     = 1'b0;
    if (load) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = zero ? DONE : RUN;
          tc_d    = zero;
        end
        RUN: if (pause) state_d = PAUSE;
        else if (zero) state_d = DONE;
        else if (one) begin
          tc_d = 1'b1;
`ifdef LOAD_DOWN_TIMER_AUTORELOAD_EN
          reload = 1'b1;
`else
          dec     = 1'b1;
          state_d = DONE;
`endif
        end else dec = 1'b1;
        PAUSE: if (!pause) state_d = RUN;
        DONE: if (start) begin
          reload  = 1'b1;
          state_d = preset_zero ? DONE : RUN;
          tc_d    = preset_zero;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end
  assign tc   = tc_q;
  assign busy = state_q == RUN || state_q == PAUSE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_load_down_timer.sv
// tb_load_down_timer: directed self-checking bench for load_down_timer at WIDTH=4.
module tb_load_down_timer;
  logic       clk = 1'b0;
  logic       rst, load, start, pause;
  logic [3:0] data, q;
  logic       tc, busy, done;
  int total = 0;
  int bad = 0;
  logic [6:0] exp_v;
  load_down_timer #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .start(start),
    .pause(pause),
    .q    (q),
    .tc   (tc),
    .busy (busy),
    .done (done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [3:0] v);
    load = 1'b1; data = v; tick(); load = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; load = 1'b1; data = 4'd7; pause = 1'b0;
    tick(); tick();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL reset got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    load = 1'b0; start = 1'b0; rst = 1'b0;
    tick();
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
  endtask
  task automatic test_count();
    do_load(4'd5);
    exp_v = {4'd5, 1'b0, 1'b0, 1'b0};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL load5 got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {4'd5, 1'b0, 1'b1, 1'b0};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL start5 got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    for (int i = 4; i >= 0; i--) begin
      tick();
      exp_v = {4'(i), i == 0, i != 0, i == 0};
      total++;
      if ({q, tc, busy, done} !== exp_v) begin
        bad++; $display("FAIL count5 step %0d got=%h exp=%h", i, {q, tc, busy, done}, exp_v);
      end
    end
    tick();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL done_hold got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
  endtask
  task automatic test_pause();
    do_load(4'd6);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = {4'd4, 1'b0, 1'b1, 1'b0};
      total++;
      if ({q, tc, busy, done} !== exp_v) begin
        bad++; $display("FAIL pause hold %0d got=%h exp=%h", i, {q, tc, busy, done}, exp_v);
      end
    end
    pause = 1'b0;
    tick();
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL pause resume got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    for (int i = 3; i >= 0; i--) begin
      tick();
      exp_v = {4'(i), i == 0, i != 0, i == 0};
      total++;
      if ({q, tc, busy, done} !== exp_v) begin
        bad++; $display("FAIL pause count %0d got=%h exp=%h", i, {q, tc, busy, done}, exp_v);
      end
    end
  endtask
  task automatic test_abort();
    do_load(4'd5);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    do_load(4'd9);
    exp_v = {4'd9, 1'b0, 1'b0, 1'b0};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL abort got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    pause = 1'b1; tick(); tick(); pause = 1'b0;
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL idle_hold got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
  endtask
  task automatic test_zero_restart();
    do_load(4'd0);
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL zero_start got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    tick();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL zero_tc_once got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL zero_restart got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    do_load(4'd3);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL run3 got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    start = 1'b1; tick(); start = 1'b0;
    exp_v = {4'd3, 1'b0, 1'b1, 1'b0};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL restart3 got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    for (int i = 2; i >= 0; i--) begin
      start = (i == 1);
      tick();
      exp_v = {4'(i), i == 0, i != 0, i == 0};
      total++;
      if ({q, tc, busy, done} !== exp_v) begin
        bad++; $display("FAIL restart count %0d got=%h exp=%h", i, {q, tc, busy, done}, exp_v);
      end
    end
    start = 1'b0;
  endtask
  task automatic test_max();
    do_load(4'd15);
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    exp_v = {4'd1, 1'b0, 1'b1, 1'b0};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL max_pre got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    tick();
    exp_v = {4'd0, 1'b1, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL max_tc got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
    tick(); tick();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    total++;
    if ({q, tc, busy, done} !== exp_v) begin
      bad++; $display("FAIL no_wrap got=%h exp=%h", {q, tc, busy, done}, exp_v);
    end
  endtask
`ifdef LOAD_DOWN_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [3:0] seq [7];
    seq = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
    do_load(4'd3);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_v = {seq[i], seq[i] == 4'd3, 1'b1, 1'b0};
      total++;
      if ({q, tc, busy, done} !== exp_v) begin
        bad++; $display("FAIL autoreload step %0d got=%h exp=%h", i, {q, tc, busy, done}, exp_v);
      end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_count();
    test_pause();
    test_abort();
    test_zero_restart();
    test_max();
`ifdef LOAD_DOWN_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
